// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a start-PC header and big-endian words
// into instruction memory, then releases the core.
module imem_boot_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_run,
  output logic [31:0]       init_pc,
  output logic [ADDR_W:0]   word_count,
  output logic              error
);

  typedef enum logic [2:0] {
    HDR, BODY, FLUSH, DONE, ERR
  } state_t;

  state_t      state;
  logic [1:0]  byteCnt;
  logic [23:0] shReg;
  logic        memWe;
  logic        accept;
  logic        lastByte;
  logic        full;
  logic [31:0] word;

  assign accept   = in_valid && in_ready;
  assign lastByte = byteCnt == 2'd3;
  assign full     = word_count == (ADDR_W+1)'(DEPTH);
  assign word     = {shReg, in_data};

  // A reset landing on a pending write suppresses it in that same cycle.
  assign mem_we   = memWe && !rst;
  assign in_ready = !rst && (state == HDR || state == BODY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HDR;
      byteCnt    <= '0;
      shReg      <= '0;
      memWe      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_run   <= 1'b0;
      init_pc    <= '0;
      word_count <= '0;
      error      <= 1'b0;
    end else begin
      memWe <= 1'b0;
      unique case (state)
        HDR: if (accept) begin
          shReg   <= word[23:0];
          byteCnt <= byteCnt + 2'd1;
          if (lastByte) begin
            init_pc <= word;
            state   <= in_last ? FLUSH : BODY;
          end else if (in_last) begin
            state <= ERR;
            error <= 1'b1;
          end
        end
        BODY: if (accept) begin
          if (full) begin
            state <= ERR;
            error <= 1'b1;
          end else begin
            shReg   <= word[23:0];
            byteCnt <= byteCnt + 2'd1;
            if (lastByte) begin
              memWe      <= 1'b1;
              mem_addr   <= word_count[ADDR_W-1:0];
              mem_wdata  <= word;
              word_count <= word_count + (ADDR_W+1)'(1);
              if (in_last) state <= FLUSH;
            end else if (in_last) begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        FLUSH: begin
          state    <= DONE;
          core_run <= 1'b1;
        end
        DONE: ;
        ERR: ;
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: table-driven image loads with a write
// scoreboard and hand-written reset/overflow sequences.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_run;
  logic [31:0] init_pc;
  logic [8:0]  word_count;
  logic        error;

  imem_boot_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_run(core_run), .init_pc(init_pc),
    .word_count(word_count), .error(error)
  );

  always #5 clk = ~clk;

  int nChk = 0;
  int nFail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          at;
  } wr_t;

  wr_t sb[$];

  typedef struct {
    logic [31:0] pc;
    int          hdrBytes;
    int          nWords;
    int          tail;
    bit          extra;
    bit          gaps;
    logic [31:0] expPc;
    int          expCount;
    bit          expErr;
    bit          expRun;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {24'd0, mem_addr, mem_wdata}, 64'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.addr));
        chk("wr_data", 64'(mem_wdata), 64'(e.data));
        chk("wr_latency", 64'(cyc), 64'(e.at));
      end
    end
  end

  function automatic logic [31:0] wordOf(input int i);
    if (i == 0) return 32'h2008_0005;
    if (i == 1) return 32'h2009_000A;
    return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  task automatic sendByte(input logic [7:0] b, input bit last,
                          input bit gaps, input bit push,
                          input int addr, input logic [31:0] data);
    wr_t e;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (push) begin
      e.addr = 8'(addr);
      e.data = data;
      e.at   = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic doReset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_outputs",
        {mem_we, core_run, error, 1'b0, 3'd0, word_count,
         mem_addr, init_pc}, 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(in_ready), 64'd1);
  endtask

  task automatic runVec(input vec_t v);
    bit lastHdr;
    bit lastW;
    logic [31:0] w;
    lastHdr = (v.hdrBytes < 4) ||
              (v.nWords == 0 && v.tail == 0 && !v.extra);
    for (int k = 0; k < v.hdrBytes; k++)
      sendByte(8'(v.pc >> (24 - 8 * k)),
               lastHdr && k == v.hdrBytes - 1, v.gaps, 1'b0, 0, '0);
    if (v.hdrBytes == 4) begin
      for (int i = 0; i < v.nWords; i++) begin
        w = wordOf(i);
        lastW = (i == v.nWords - 1) && v.tail == 0 && !v.extra;
        for (int k = 0; k < 4; k++)
          sendByte(8'(w >> (24 - 8 * k)), lastW && k == 3,
                   v.gaps, k == 3, i, w);
      end
      for (int k = 0; k < v.tail; k++)
        sendByte(8'hEE, k == v.tail - 1, v.gaps, 1'b0, 0, '0);
      if (v.extra)
        sendByte(8'h77, 1'b1, v.gaps, 1'b0, 0, '0);
    end
    @(negedge clk);
    chk("t1_in_ready", 64'(in_ready), 64'd0);
    chk("t1_core_run", 64'(core_run), 64'd0);
    chk("t1_error", 64'(error), 64'(v.expErr));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t2_core_run", 64'(core_run), 64'(v.expRun));
    chk("t2_error", 64'(error), 64'(v.expErr));
    chk("t2_init_pc", 64'(init_pc), 64'(v.expPc));
    chk("t2_word_count", 64'(word_count), 64'(v.expCount));
    chk("t2_in_ready", 64'(in_ready), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h10, 4, 2, 0, 0, 0, 32'h10, 2, 0, 1};
    vecs[1] = '{32'h10, 4, 2, 0, 0, 1, 32'h10, 2, 0, 1};
    vecs[2] = '{32'h80, 4, 0, 0, 0, 0, 32'h80, 0, 0, 1};
    vecs[3] = '{32'h04, 4, 2, 2, 0, 0, 32'h04, 2, 1, 0};
    vecs[4] = '{32'h44, 2, 0, 0, 0, 0, 32'h00, 0, 1, 0};
    vecs[5] = '{32'h100, 4, 256, 0, 1, 0, 32'h100, 256, 1, 0};
    vecs[6] = '{32'hFFFF_FFFC, 4, 3, 0, 0, 1,
                32'hFFFF_FFFC, 3, 0, 1};

    for (int i = 0; i < 7; i++) begin
      doReset();
      runVec(vecs[i]);
    end

    // Reset lands in the cycle the first word's write would appear.
    doReset();
    for (int k = 0; k < 4; k++)
      sendByte(8'(32'h20 >> (24 - 8 * k)), 1'b0, 1'b0, 1'b0, 0, '0);
    for (int k = 0; k < 4; k++)
      sendByte(8'(32'h1122_3344 >> (24 - 8 * k)), 1'b0, 1'b0,
               1'b0, 0, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_we", 64'(mem_we), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_pc", 64'(init_pc), 64'd0);
    chk("mid_rst_count", 64'(word_count), 64'd0);
    chk("mid_rst_flags", {61'd0, core_run, error, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    runVec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChk, nFail);
    $finish;
  end

endmodule
